seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//   Receive-side counterpart of the clock display driver: samples the multiplexed
//   7-segment bus (anodes/cnodes), tracks the digit scan and decodes each lit pattern
//   back to a hex nibble. Publishes a coherent 8-digit snapshot once per full scan.
//   Used as a display monitor on the board and as a scoreboard front-end in the benches.
// PARAMETERS
//   DIGITS   8     number of multiplexed digits (anode width)
//   SETTLE   4     cycles an anode selection must stay stable before its segments are captured
//   TIMEOUT  1024  cycles with no completed frame before stale is raised
// PORTS
//   clk_src      in   1         single system clock, all logic on rising edge
//   reset_n      in   1         synchronous, active-low reset
//   anodes       in   DIGITS    digit select, active-low, one-cold when valid
//   cnodes       in   8         segments {dp,g,f,e,d,c,b,a}, active-low
//   digits       out  4*DIGITS  decoded nibbles, digit k at [4k+3:4k]
//   dp           out  DIGITS    decimal point per digit, 1 = lit
//   blank        out  DIGITS    digit k had all of a..g off
//   digit_err    out  DIGITS    digit k carried an unrecognised pattern
//   frame_valid  out  1         one-cycle pulse: outputs just updated with a complete frame
//   scan_err     out  1         one-cycle pulse: more than one anode low
//   stale        out  1         no complete frame for TIMEOUT cycles
// BEHAVIOUR
//   - Reset (reset_n=0 at an edge): digits/dp/blank/digit_err=0, frame_valid=0,
//     scan_err=0, stale=1, seen mask/settle/timeout counters cleared. Applies mid-frame too.
//   - Input stage: anodes/cnodes registered once (a_q, c_q); all decisions use a_q/c_q.
//   - Settle counter: a_q one-cold and equal to previous a_q -> increment (saturates at
//     SETTLE); otherwise reload to 1 if a_q is one-cold, else 0.
//   - Capture exactly once per dwell, on the cycle the counter reaches SETTLE:
//     shadow[k] <= decode(c_q[6:0]), dp_sh[k] <= ~c_q[7], seen[k] <= 1.
//   - Decode (a..g active-low): standard hex 0-F set (0=C0,1=F9,2=A4,3=B0,4=99,5=92,
//     6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E, dp bit masked); all-off ->
//     value 0 with blank; any other pattern -> value F with err flag.
//   - Recapture of an already-seen digit before the frame completes overwrites its shadow.
//   - Frame: cycle after seen becomes all-ones: digits/dp/blank/digit_err <= shadow set
//     (atomic), frame_valid=1 for 1 cycle, seen cleared, timeout counter cleared, stale=0.
//     A capture in the same cycle as the frame publish sets seen for the new frame.
//   - anodes all high (display off): no capture, settle=0, seen retained.
//   - a_q with >=2 zeros: scan_err=1 on the first cycle of each such run only; no capture.
//   - Timeout counter increments every cycle, saturates at TIMEOUT; stale=1 at TIMEOUT.
//   - Latency: pin change -> capture = 1 + SETTLE cycles; last capture -> frame_valid = 1.
// STRUCTURE
//   - Shared package seg_pkg: SEG_0..SEG_F, SEG_BLANK active-low localparams,
//     seg_t typedef (8-bit), DIGIT_W=4.
//   - Sub-module seg7_decode: combinational 7-bit pattern -> {nibble, blank, err};
//     top holds input regs, settle/timeout counters, seen mask, shadow and output regs.
// TESTING
//   1 reset_n=0 3 cycles -> digits=0, frame_valid=0, scan_err=0, stale=1.
//   2 scan k=0..7, anode k low, cnodes = code for k, 8 cycles each -> one frame_valid
//     pulse, digits=32'h76543210, blank=0, digit_err=0, stale=0.
//   3 digit 2 dwell 3 cycles (<SETTLE), others normal -> no frame_valid; rescan 2 for 8
//     cycles -> frame_valid, nibble 2 correct.
//   4 anodes=8'b1111_0011 for 5 cycles -> scan_err high exactly 1 cycle, seen unchanged.
//   5 digit 0 cnodes=8'hAA, digit 1 cnodes=8'hFF, digit 3 cnodes=8'h40 -> digit_err[0]=1
//     nibble F; blank[1]=1 nibble 0; dp[3]=1 nibble 0.
//   6 stop scan 1024 cycles -> stale=1; resume full scan -> stale=0 with frame_valid;
//     reset_n low after 4 digits captured, then 4 more -> no frame_valid.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// rtl/seg_scan_decoder_pkg.sv - shared segment codes and widths for the scan decoder
// Purpose: active-low 7-segment code constants {dp,g,f,e,d,c,b,a}, the
//          segment bus type and the decoded digit width.
// Ports:   none (package)
package seg_scan_decoder_pkg;

  typedef logic [7:0] seg_t;

  localparam int DIGIT_W = 4;

  // Active-low codes with the decimal point off (bit 7 high).
  localparam seg_t SEG_0     = 8'hC0;
  localparam seg_t SEG_1     = 8'hF9;
  localparam seg_t SEG_2     = 8'hA4;
  localparam seg_t SEG_3     = 8'hB0;
  localparam seg_t SEG_4     = 8'h99;
  localparam seg_t SEG_5     = 8'h92;
  localparam seg_t SEG_6     = 8'h82;
  localparam seg_t SEG_7     = 8'hF8;
  localparam seg_t SEG_8     = 8'h80;
  localparam seg_t SEG_9     = 8'h90;
  localparam seg_t SEG_A     = 8'h88;
  localparam seg_t SEG_B     = 8'h83;
  localparam seg_t SEG_C     = 8'hC6;
  localparam seg_t SEG_D     = 8'hA1;
  localparam seg_t SEG_E     = 8'h86;
  localparam seg_t SEG_F     = 8'h8E;
  localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - multiplexed 7-segment display bus
// Purpose: groups the digit-select and segment lines of a scanned display.
// Ports:   anodes [DIGITS-1:0] digit select, active-low, one-cold when valid
//          cnodes [7:0]        segments {dp,g,f,e,d,c,b,a}, active-low
//          master drives the bus (display driver), slave observes it (decoder)
interface seg_scan_decoder_if #(
  parameter int DIGITS = 8
);
  import seg_scan_decoder_pkg::*;

  logic [DIGITS-1:0] anodes;
  seg_t              cnodes;

  modport master (output anodes, output cnodes);
  modport slave  (input  anodes, input  cnodes);

endinterface

// File: rtl/seg_scan_decoder_seg7_decode.sv
// rtl/seg_scan_decoder_seg7_decode.sv - combinational 7-segment pattern to hex nibble
// Purpose: maps an active-low a..g pattern back to its hex value.
// Ports:   i_seg    [6:0] segments {g,f,e,d,c,b,a}, active-low
//          o_nibble [3:0] decoded value (0 when blank, F when unrecognised)
//          o_blank        all segments off
//          o_err          pattern is neither a hex glyph nor blank
module seg7_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0]         i_seg,
  output logic [DIGIT_W-1:0] o_nibble,
  output logic               o_blank,
  output logic               o_err
);

  seg_t w_pat;

  always_comb begin
    // Force dp off so the match ignores the decimal point.
    w_pat    = {1'b1, i_seg};
    o_nibble = 4'hF;
    o_blank  = 1'b0;
    o_err    = 1'b0;
    case (w_pat)
      SEG_0:     o_nibble = 4'h0;
      SEG_1:     o_nibble = 4'h1;
      SEG_2:     o_nibble = 4'h2;
      SEG_3:     o_nibble = 4'h3;
      SEG_4:     o_nibble = 4'h4;
      SEG_5:     o_nibble = 4'h5;
      SEG_6:     o_nibble = 4'h6;
      SEG_7:     o_nibble = 4'h7;
      SEG_8:     o_nibble = 4'h8;
      SEG_9:     o_nibble = 4'h9;
      SEG_A:     o_nibble = 4'hA;
      SEG_B:     o_nibble = 4'hB;
      SEG_C:     o_nibble = 4'hC;
      SEG_D:     o_nibble = 4'hD;
      SEG_E:     o_nibble = 4'hE;
      SEG_F:     o_nibble = 4'hF;
      SEG_BLANK: begin
        o_nibble = 4'h0;
        o_blank  = 1'b1;
      end
      default:   o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 7-segment bus monitor publishing full-frame snapshots
// Purpose: samples a multiplexed display bus, waits for each anode dwell to
//          settle, decodes the lit digit and publishes all digits atomically
//          once every digit has been captured.
// Ports:   i_clk_src       system clock, rising edge
//          i_reset_n       synchronous active-low reset
//          bus             display bus (slave): anodes / cnodes
//          o_digits        decoded nibbles, digit k at [4k+3:4k]
//          o_dp            decimal point per digit, 1 = lit
//          o_blank         digit had all of a..g off
//          o_digit_err     digit carried an unrecognised pattern
//          o_frame_valid   one-cycle pulse when the outputs take a new frame
//          o_scan_err      one-cycle pulse at the start of a multi-anode run
//          o_stale         no complete frame for TIMEOUT cycles
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                        i_clk_src,
  input  logic                        i_reset_n,
  seg_scan_decoder_if.slave           bus,
  output logic [DIGIT_W*DIGITS-1:0]   o_digits,
  output logic [DIGITS-1:0]           o_dp,
  output logic [DIGITS-1:0]           o_blank,
  output logic [DIGITS-1:0]           o_digit_err,
  output logic                        o_frame_valid,
  output logic                        o_scan_err,
  output logic                        o_stale
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [DIGITS-1:0]         r_a_q;
  logic [DIGITS-1:0]         r_a_prev;
  seg_t                      r_c_q;
  logic [SW-1:0]             r_settle;
  logic [TW-1:0]             r_tmo;
  logic [DIGITS-1:0]         r_seen;
  logic                      r_multi_d;

  logic [DIGIT_W*DIGITS-1:0] r_sh_nib;
  logic [DIGITS-1:0]         r_sh_dp;
  logic [DIGITS-1:0]         r_sh_blank;
  logic [DIGITS-1:0]         r_sh_err;

  logic [DIGIT_W*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]         r_dp;
  logic [DIGITS-1:0]         r_blank;
  logic [DIGITS-1:0]         r_digit_err;
  logic                      r_frame_valid;
  logic                      r_scan_err;
  logic                      r_stale;

  int                        w_zeros;
  logic                      w_one_cold;
  logic                      w_multi;
  logic                      w_same;
  logic [SW-1:0]             w_settle_nxt;
  logic                      w_capture;
  logic                      w_publish;
  logic [DIGITS-1:0]         w_sel;
  logic [DIGITS-1:0]         w_seen_nxt;
  logic [DIGIT_W-1:0]        w_dec_nib;
  logic                      w_dec_blank;
  logic                      w_dec_err;

  seg7_decode u_decode (
    .i_seg    (r_c_q[6:0]),
    .o_nibble (w_dec_nib),
    .o_blank  (w_dec_blank),
    .o_err    (w_dec_err)
  );

  always_comb begin
    w_zeros    = $countones(~r_a_q);
    w_one_cold = (w_zeros == 1);
    w_multi    = (w_zeros >= 2);
    w_same     = (r_a_q == r_a_prev);
    w_sel      = ~r_a_q;

    if (w_one_cold && w_same) begin
      w_settle_nxt = (r_settle == SW'(SETTLE)) ? r_settle : r_settle + 1'b1;
    end else if (w_one_cold) begin
      w_settle_nxt = SW'(1);
    end else begin
      w_settle_nxt = '0;
    end

    // Capture only on the transition into SETTLE, never while parked there.
    w_capture = w_one_cold && (w_settle_nxt == SW'(SETTLE)) &&
                !(w_same && (r_settle == SW'(SETTLE)));

    w_publish = &r_seen;

    // A capture on the publish cycle belongs to the next frame.
    w_seen_nxt = (w_publish ? '0 : r_seen) | (w_capture ? w_sel : '0);
  end

  always_ff @(posedge i_clk_src) begin
    if (!i_reset_n) begin
      r_a_q         <= '1;
      r_a_prev      <= '1;
      r_c_q         <= SEG_BLANK;
      r_settle      <= '0;
      r_tmo         <= '0;
      r_seen        <= '0;
      r_multi_d     <= 1'b0;
      r_sh_nib      <= '0;
      r_sh_dp       <= '0;
      r_sh_blank    <= '0;
      r_sh_err      <= '0;
      r_digits      <= '0;
      r_dp          <= '0;
      r_blank       <= '0;
      r_digit_err   <= '0;
      r_frame_valid <= 1'b0;
      r_scan_err    <= 1'b0;
      r_stale       <= 1'b1;
    end else begin
      r_a_q      <= bus.anodes;
      r_c_q      <= bus.cnodes;
      r_a_prev   <= r_a_q;
      r_settle   <= w_settle_nxt;
      r_seen     <= w_seen_nxt;
      r_multi_d  <= w_multi;
      r_scan_err <= w_multi && !r_multi_d;

      for (int k = 0; k < DIGITS; k++) begin
        if (w_capture && w_sel[k]) begin
          r_sh_nib[k*DIGIT_W +: DIGIT_W] <= w_dec_nib;
          r_sh_dp[k]                     <= ~r_c_q[7];
          r_sh_blank[k]                  <= w_dec_blank;
          r_sh_err[k]                    <= w_dec_err;
        end
      end

      r_frame_valid <= w_publish;
      if (w_publish) begin
        r_digits    <= r_sh_nib;
        r_dp        <= r_sh_dp;
        r_blank     <= r_sh_blank;
        r_digit_err <= r_sh_err;
        r_tmo       <= '0;
        r_stale     <= 1'b0;
      end else begin
        if (r_tmo != TW'(TIMEOUT)) begin
          r_tmo <= r_tmo + 1'b1;
        end
        if (r_tmo >= TW'(TIMEOUT - 1)) begin
          r_stale <= 1'b1;
        end
      end
    end
  end

  assign o_digits      = r_digits;
  assign o_dp          = r_dp;
  assign o_blank       = r_blank;
  assign o_digit_err   = r_digit_err;
  assign o_frame_valid = r_frame_valid;
  assign o_scan_err    = r_scan_err;
  assign o_stale       = r_stale;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] o_digits;
  logic [7:0]  o_dp;
  logic [7:0]  o_blank;
  logic [7:0]  o_digit_err;
  logic        o_frame_valid;
  logic        o_scan_err;
  logic        o_stale;

  int n_checks = 0;
  int n_errors = 0;
  int fv_cnt   = 0;
  int se_cnt   = 0;
  int fv_base;
  int se_base;

  logic [7:0] code [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  seg_scan_decoder_if #(.DIGITS(8)) bus ();

  seg_scan_decoder #(.DIGITS(8), .SETTLE(4), .TIMEOUT(1024)) dut (
    .i_clk_src     (clk),
    .i_reset_n     (reset_n),
    .bus           (bus),
    .o_digits      (o_digits),
    .o_dp          (o_dp),
    .o_blank       (o_blank),
    .o_digit_err   (o_digit_err),
    .o_frame_valid (o_frame_valid),
    .o_scan_err    (o_scan_err),
    .o_stale       (o_stale)
  );

  always @(negedge clk) begin
    if (o_frame_valid) fv_cnt++;
    if (o_scan_err) se_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic [7:0] c, input int n);
    bus.anodes = ~(8'b1 << k);
    bus.cnodes = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.anodes = 8'hFF;
    bus.cnodes = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.anodes = 8'hFF;
    bus.cnodes = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_digits", o_digits, 32'h0);
    check("rst_fv", {31'b0, o_frame_valid}, 32'h0);
    check("rst_scan_err", {31'b0, o_scan_err}, 32'h0);
    check("rst_stale", {31'b0, o_stale}, 32'h1);
    check("rst_dp", {24'b0, o_dp}, 32'h0);
    check("rst_blank", {24'b0, o_blank}, 32'h0);
    check("rst_err", {24'b0, o_digit_err}, 32'h0);
    reset_n = 1'b1;

    // full scan 0..7
    fv_base = fv_cnt;
    for (int k = 0; k < 8; k++) drive(k, code[k], 8);
    idle(4);
    check("scan_fv", fv_cnt - fv_base, 32'd1);
    check("scan_digits", o_digits, 32'h76543210);
    check("scan_blank", {24'b0, o_blank}, 32'h0);
    check("scan_err_flags", {24'b0, o_digit_err}, 32'h0);
    check("scan_stale", {31'b0, o_stale}, 32'h0);

    // short dwell on digit 2 must not capture
    fv_base = fv_cnt;
    for (int k = 0; k < 8; k++) drive(k, code[k+8], (k == 2) ? 3 : 8);
    idle(4);
    check("short_no_fv", fv_cnt - fv_base, 32'd0);
    drive(2, code[10], 8);
    idle(4);
    check("rescan_fv", fv_cnt - fv_base, 32'd1);
    check("rescan_digits", o_digits, 32'hFEDCBA98);
    check("rescan_nib2", {28'b0, o_digits[11:8]}, 32'hA);

    // two anodes low: single scan_err pulse, seen mask untouched
    fv_base = fv_cnt;
    se_base = se_cnt;
    for (int k = 0; k < 7; k++) drive(k, code[7-k], 8);
    bus.anodes = 8'b1111_0011;
    bus.cnodes = code[0];
    repeat (5) @(negedge clk);
    idle(4);
    check("multi_scan_err", se_cnt - se_base, 32'd1);
    check("multi_no_fv", fv_cnt - fv_base, 32'd0);
    drive(7, code[0], 8);
    idle(4);
    check("multi_then_fv", fv_cnt - fv_base, 32'd1);
    check("multi_digits", o_digits, 32'h01234567);

    // invalid, blank and decimal-point patterns
    fv_base = fv_cnt;
    drive(0, 8'hAA, 8);
    drive(1, 8'hFF, 8);
    drive(2, code[2], 8);
    drive(3, 8'h40, 8);
    for (int k = 4; k < 8; k++) drive(k, code[k], 8);
    idle(4);
    check("pat_fv", fv_cnt - fv_base, 32'd1);
    check("pat_digits", o_digits, 32'h7654020F);
    check("pat_blank", {24'b0, o_blank}, 32'h02);
    check("pat_err", {24'b0, o_digit_err}, 32'h01);
    check("pat_dp", {24'b0, o_dp}, 32'h08);

    // timeout and recovery
    idle(900);
    check("tmo_not_yet", {31'b0, o_stale}, 32'h0);
    idle(200);
    check("tmo_stale", {31'b0, o_stale}, 32'h1);
    fv_base = fv_cnt;
    for (int k = 0; k < 8; k++) drive(k, code[15-k], 8);
    idle(4);
    check("resume_fv", fv_cnt - fv_base, 32'd1);
    check("resume_stale", {31'b0, o_stale}, 32'h0);
    check("resume_digits", o_digits, 32'h89ABCDEF);

    // reset in the middle of a frame discards the partial scan
    fv_base = fv_cnt;
    for (int k = 0; k < 4; k++) drive(k, code[k], 8);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 4; k < 8; k++) drive(k, code[k], 8);
    idle(10);
    check("midrst_no_fv", fv_cnt - fv_base, 32'd0);
    check("midrst_digits", o_digits, 32'h0);
    check("midrst_stale", {31'b0, o_stale}, 32'h1);
    check("total_scan_err", se_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
